// File: rtl/multicycle_main_ctrl_if.sv
// Control bundle between the instruction register/ALU flags and the multicycle datapath.
// master = controller (drives enables/muxes), slave = datapath (drives op/zero).
interface multicycle_main_ctrl_if;
  // No valid/ready pairing: every signal is level-valid in every cycle and
  // is consumed by the datapath on the next rising clock edge.
  logic [5:0] op;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [3:0] aluop;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, instr_done, illegal
  );

  modport slave (
    output op, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// Main Moore control FSM of the multicycle MIPS core.
// Define MAINCTRL_BNE_EN to decode bne (op 000101) instead of trapping it as illegal.
module multicycle_main_ctrl (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_main_ctrl_if.master      bus,
  output logic [3:0]                  state
);
  localparam int STATE_W = 4;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MAINCTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    ILLEGAL = 4'd12,
    BNEEX   = 4'd13
  } state_t;

  state_t state_q, state_d;
  logic   pcwrite, branch, branchne;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = FETCH;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    branchne       = 1'b0;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.aluop      = 4'b0000;
    bus.pcsrc      = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        state_d     = DECODE;
        bus.alusrcb = 2'b01;
        bus.irwrite = 1'b1;
        pcwrite     = 1'b1;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MAINCTRL_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        // op is read live here; IR only loads in FETCH so it is still the same instruction
        state_d     = (bus.op == OP_SW) ? MEMWR : MEMRD;
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD: begin
        state_d  = MEMWB;
        bus.iord = 1'b1;
      end
      MEMWB: begin
        bus.memtoreg   = 1'b1;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        bus.iord       = 1'b1;
        bus.memwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      RTYPEEX: begin
        state_d     = RTYPEWB;
        bus.alusrca = 1'b1;
        bus.aluop   = 4'b0010;
      end
      RTYPEWB: begin
        bus.regdst     = 1'b1;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      BEQEX: begin
        bus.alusrca    = 1'b1;
        bus.aluop      = 4'b0001;
        bus.pcsrc      = 2'b01;
        branch         = 1'b1;
        bus.instr_done = 1'b1;
      end
      ADDIEX: begin
        state_d     = ADDIWB;
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      ADDIWB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      JEX: begin
        bus.pcsrc      = 2'b10;
        pcwrite        = 1'b1;
        bus.instr_done = 1'b1;
      end
      ILLEGAL: begin
        // PC already advanced by 4 in FETCH, so nothing is written here
        bus.illegal    = 1'b1;
        bus.instr_done = 1'b1;
      end
`ifdef MAINCTRL_BNE_EN
      BNEEX: begin
        bus.alusrca    = 1'b1;
        bus.aluop      = 4'b0001;
        bus.pcsrc      = 2'b01;
        branchne       = 1'b1;
        bus.instr_done = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign bus.pcen = pcwrite | (branch & bus.zero) | (branchne & ~bus.zero);
  assign state    = state_q;
endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Directed bench for multicycle_main_ctrl: per-cycle expected output words go into a queue
// that a negedge monitor pops and compares.
module tb_multicycle_main_ctrl;
  localparam int W = 22;

  // Word layout: {state[3:0], iord, memwrite, irwrite, regdst, memtoreg, regwrite,
  //               alusrca, alusrcb[1:0], aluop[3:0], pcsrc[1:0], pcen, instr_done, illegal}
  localparam logic [W-1:0] X_FETCH   = {4'd0,  7'b0010000, 2'b01, 4'b0000, 2'b00, 3'b100};
  localparam logic [W-1:0] X_DECODE  = {4'd1,  7'b0000000, 2'b11, 4'b0000, 2'b00, 3'b000};
  localparam logic [W-1:0] X_MEMADR  = {4'd2,  7'b0000001, 2'b10, 4'b0000, 2'b00, 3'b000};
  localparam logic [W-1:0] X_MEMRD   = {4'd3,  7'b1000000, 2'b00, 4'b0000, 2'b00, 3'b000};
  localparam logic [W-1:0] X_MEMWB   = {4'd4,  7'b0000110, 2'b00, 4'b0000, 2'b00, 3'b010};
  localparam logic [W-1:0] X_MEMWR   = {4'd5,  7'b1100000, 2'b00, 4'b0000, 2'b00, 3'b010};
  localparam logic [W-1:0] X_RTYPEEX = {4'd6,  7'b0000001, 2'b00, 4'b0010, 2'b00, 3'b000};
  localparam logic [W-1:0] X_RTYPEWB = {4'd7,  7'b0001010, 2'b00, 4'b0000, 2'b00, 3'b010};
  localparam logic [W-1:0] X_BEQ_Z1  = {4'd8,  7'b0000001, 2'b00, 4'b0001, 2'b01, 3'b110};
  localparam logic [W-1:0] X_BEQ_Z0  = {4'd8,  7'b0000001, 2'b00, 4'b0001, 2'b01, 3'b010};
  localparam logic [W-1:0] X_ADDIEX  = {4'd9,  7'b0000001, 2'b10, 4'b0000, 2'b00, 3'b000};
  localparam logic [W-1:0] X_ADDIWB  = {4'd10, 7'b0000010, 2'b00, 4'b0000, 2'b00, 3'b010};
  localparam logic [W-1:0] X_JEX     = {4'd11, 7'b0000000, 2'b00, 4'b0000, 2'b10, 3'b110};
  localparam logic [W-1:0] X_ILLEGAL = {4'd12, 7'b0000000, 2'b00, 4'b0000, 2'b00, 3'b011};
`ifdef MAINCTRL_BNE_EN
  localparam logic [W-1:0] X_BNE_Z0  = {4'd13, 7'b0000001, 2'b00, 4'b0001, 2'b01, 3'b110};
  localparam logic [W-1:0] X_BNE_Z1  = {4'd13, 7'b0000001, 2'b00, 4'b0001, 2'b01, 3'b010};
`endif

  logic       clk;
  logic       reset;
  logic [3:0] state;
  multicycle_main_ctrl_if bus();

  logic [W-1:0] exp_q[$];
  int           checks;
  int           failures;
  int           cycle_idx;
  logic         stim_done;

  multicycle_main_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .state (state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic expect_cycle(input logic [W-1:0] exp);
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
  endtask

  task automatic set_inputs(input logic [5:0] o, input logic z);
    bus.op   = o;
    bus.zero = z;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    checks    = 0;
    failures  = 0;
    cycle_idx = 0;
    forever begin
      @(negedge clk);
      cycle_idx = cycle_idx + 1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {state, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
               bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc,
               bus.pcen, bus.instr_done, bus.illegal};
        checks = checks + 1;
        if (got !== exp) begin
          failures = failures + 1;
          $display("FAIL cycle_%0d exp_state=%0d: got=%06h expected=%06h",
                   cycle_idx, exp[W-1 -: 4], got, exp);
        end
      end else if (stim_done) begin
        checks = checks + 1;
        if (exp_q.size() != 0) begin
          failures = failures + 1;
          $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // stimulus: each instruction starts with FETCH already observed and ends by expecting FETCH
  initial begin
    stim_done = 1'b0;
    reset     = 1'b1;
    set_inputs(6'b000000, 1'b0);
    expect_cycle(X_FETCH);
    expect_cycle(X_FETCH);
    reset = 1'b0;

    // reset mid-RTYPEEX: no RTYPEWB afterwards
    set_inputs(6'b000000, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_RTYPEEX);
    reset = 1'b1;
    expect_cycle(X_FETCH);
    expect_cycle(X_FETCH);
    reset = 1'b0;

    // lw
    set_inputs(6'b100011, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_MEMADR);
    expect_cycle(X_MEMRD);
    expect_cycle(X_MEMWB);
    expect_cycle(X_FETCH);

    // R-type then sw
    set_inputs(6'b000000, 1'b1);
    expect_cycle(X_DECODE);
    expect_cycle(X_RTYPEEX);
    expect_cycle(X_RTYPEWB);
    expect_cycle(X_FETCH);
    set_inputs(6'b101011, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_MEMADR);
    expect_cycle(X_MEMWR);
    expect_cycle(X_FETCH);

    // beq taken / not taken
    set_inputs(6'b000100, 1'b1);
    expect_cycle(X_DECODE);
    expect_cycle(X_BEQ_Z1);
    expect_cycle(X_FETCH);
    set_inputs(6'b000100, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_BEQ_Z0);
    expect_cycle(X_FETCH);

    // addi
    set_inputs(6'b001000, 1'b1);
    expect_cycle(X_DECODE);
    expect_cycle(X_ADDIEX);
    expect_cycle(X_ADDIWB);
    expect_cycle(X_FETCH);

    // j, then illegal opcodes
    set_inputs(6'b000010, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_JEX);
    expect_cycle(X_FETCH);
    set_inputs(6'b111111, 1'b1);
    expect_cycle(X_DECODE);
    expect_cycle(X_ILLEGAL);
    expect_cycle(X_FETCH);
    set_inputs(6'b001101, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_ILLEGAL);
    expect_cycle(X_FETCH);

    // bne opcode
`ifdef MAINCTRL_BNE_EN
    set_inputs(6'b000101, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_BNE_Z0);
    expect_cycle(X_FETCH);
    set_inputs(6'b000101, 1'b1);
    expect_cycle(X_DECODE);
    expect_cycle(X_BNE_Z1);
    expect_cycle(X_FETCH);
`else
    set_inputs(6'b000101, 1'b0);
    expect_cycle(X_DECODE);
    expect_cycle(X_ILLEGAL);
    expect_cycle(X_FETCH);
`endif

    @(posedge clk);
    #1;
    stim_done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
